// File: rtl/snake_pkg.sv
// ============================================================================
// Module      : snake_pkg
// Description : Shared game-status codes, cell codes and playfield bounds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snake_pkg;

   localparam logic [1:0] GS_RESTART = 2'b00;
   localparam logic [1:0] GS_PLAY    = 2'b10;

   typedef enum logic [1:0] {
      CELL_NONE = 2'd0,
      CELL_HEAD = 2'd1,
      CELL_BODY = 2'd2,
      CELL_WALL = 2'd3
   } cell_e;

   localparam logic [5:0] X_MIN      = 6'd1;
   localparam logic [5:0] X_MAX      = 6'd34;
   localparam logic [5:0] Y_MIN      = 6'd1;
   localparam logic [5:0] Y_MAX      = 6'd24;
   localparam int         CELL_SHIFT = 4;

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_EAT    = 2'd1,
      ST_PLACE  = 2'd2
   } apple_state_e;

   function automatic logic in_playfield(input logic [5:0] cx, input logic [5:0] cy);
      return (cx >= X_MIN) && (cx <= X_MAX) && (cy >= Y_MIN) && (cy <= Y_MAX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/snake_lfsr16.sv
// ============================================================================
// Module      : snake_lfsr16
// Description : 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, with enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   output logic [15:0] state_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;
   logic        fb;

   always_comb begin
      fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
      lfsr_d = {lfsr_q[14:0], fb};
      // The all-zero lock-up state is unreachable from a nonzero seed; recover anyway.
      if (lfsr_q == 16'h0000) begin
         lfsr_d = SEED;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else if (en_i) begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/apple_generator.sv
// ============================================================================
// Module      : apple_generator
// Description : Apple position, eat detection, grow pulse, eaten counter and
//               LFSR-based re-placement inside the playfield.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apple_generator
   import snake_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter logic [5:0]  INIT_X    = 6'd24,
   parameter logic [5:0]  INIT_Y    = 6'd10,
   parameter int          ADD_PULSE = 4,
   parameter int          MAX_TRIES = 32,
   parameter logic [5:0]  FALL_X    = 6'd17,
   parameter logic [5:0]  FALL_Y    = 6'd12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] game_status,
   input  logic [5:0] head_x,
   input  logic [5:0] head_y,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   output logic       add_cube,
   output logic       apple,
   output logic [5:0] apple_x,
   output logic [5:0] apple_y,
   output logic [7:0] apple_cnt
);

   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   logic [15:0]  lfsr_w;
   logic         lfsr_unused;
   logic [5:0]   cand_x;
   logic [5:0]   cand_y;
   logic         cand_ok;
   logic [5:0]   scan_x;
   logic [5:0]   scan_y;

   apple_state_e     state_q;
   logic             add_cube_q;
   logic [5:0]       apple_x_q;
   logic [5:0]       apple_y_q;
   logic             apple_valid_q;
   logic [7:0]       apple_cnt_q;
   logic [3:0]       pulse_q;
   logic [TRY_W-1:0] tries_q;

   snake_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .en_i    (1'b1),
      .state_o (lfsr_w)
   );

   assign lfsr_unused = ^{lfsr_w[15:13], lfsr_w[7:6]};
   assign cand_x      = lfsr_w[5:0];
   assign cand_y      = {1'b0, lfsr_w[12:8]};
   assign cand_ok     = in_playfield(cand_x, cand_y) && ({cand_x, cand_y} != {head_x, head_y});

   assign scan_x = 6'(x_pos >> CELL_SHIFT);
   assign scan_y = 6'(y_pos >> CELL_SHIFT);
   assign apple  = apple_valid_q && (scan_x == apple_x_q) && (scan_y == apple_y_q);

   always_ff @(posedge clk) begin
      if (rst || (game_status == GS_RESTART)) begin
         state_q       <= ST_ACTIVE;
         add_cube_q    <= 1'b0;
         apple_x_q     <= INIT_X;
         apple_y_q     <= INIT_Y;
         apple_valid_q <= 1'b1;
         apple_cnt_q   <= 8'd0;
         pulse_q       <= 4'd0;
         tries_q       <= '0;
      end else begin
         case (state_q)
            ST_ACTIVE: begin
               if ((game_status == GS_PLAY) && ({head_x, head_y} == {apple_x_q, apple_y_q})) begin
                  state_q       <= ST_EAT;
                  add_cube_q    <= 1'b1;
                  apple_valid_q <= 1'b0;
                  pulse_q       <= 4'd1;
                  if (apple_cnt_q != 8'hFF) begin
                     apple_cnt_q <= apple_cnt_q + 8'd1;
                  end
               end
            end
            ST_EAT: begin
               // pulse_q counts the cycles add_cube has already been high.
               if (pulse_q == 4'(ADD_PULSE)) begin
                  add_cube_q <= 1'b0;
                  tries_q    <= '0;
                  state_q    <= ST_PLACE;
               end else begin
                  pulse_q <= pulse_q + 4'd1;
               end
            end
            ST_PLACE: begin
               if (cand_ok) begin
                  apple_x_q     <= cand_x;
                  apple_y_q     <= cand_y;
                  apple_valid_q <= 1'b1;
                  state_q       <= ST_ACTIVE;
               end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                  apple_x_q     <= FALL_X;
                  apple_y_q     <= FALL_Y;
                  apple_valid_q <= 1'b1;
                  state_q       <= ST_ACTIVE;
               end else begin
                  tries_q <= tries_q + 1'b1;
               end
            end
            default: begin
               state_q    <= ST_ACTIVE;
               add_cube_q <= 1'b0;
            end
         endcase
      end
   end

   assign add_cube  = add_cube_q;
   assign apple_x   = apple_x_q;
   assign apple_y   = apple_y_q;
   assign apple_cnt = apple_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_apple_generator.sv
// ============================================================================
// Module      : tb_apple_generator
// Description : Directed self-checking bench for apple_generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apple_generator;
   import snake_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] game_status;
   logic [5:0] head_x, head_y;
   logic [9:0] x_pos, y_pos;
   logic       add_cube, apple;
   logic [5:0] apple_x, apple_y;
   logic [7:0] apple_cnt;

   int checks = 0;
   int errors = 0;
   logic [15:0] lfsr_m;

   apple_generator dut (
      .clk         (clk),
      .rst         (rst),
      .game_status (game_status),
      .head_x      (head_x),
      .head_y      (head_y),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .add_cube    (add_cube),
      .apple       (apple),
      .apple_x     (apple_x),
      .apple_y     (apple_y),
      .apple_cnt   (apple_cnt)
   );

   always #5 clk = ~clk;

   // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting left, stepping every cycle.
   always @(posedge clk) begin
      if (rst) lfsr_m <= 16'hACE1;
      else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_active(input string tag);
      int n = 0;
      while ((dut.state_q != ST_ACTIVE) && (n < 60)) begin
         tick();
         n++;
      end
      if (dut.state_q != ST_ACTIVE) chk(tag, 32'(dut.state_q), 32'(ST_ACTIVE));
   endtask

   task automatic set_pix(input int px, input int py);
      x_pos = 10'(px);
      y_pos = 10'(py);
      #1;
   endtask

   int highs;
   int place_cycles;
   int seen;

   initial begin
      rst = 1'b1; game_status = GS_PLAY; head_x = 6'd10; head_y = 6'd5;
      x_pos = '0; y_pos = '0;
      tick(); tick();
      chk("rst_add_cube", add_cube, 0);
      chk("rst_apple_x", apple_x, 24);
      chk("rst_apple_y", apple_y, 10);
      chk("rst_cnt", apple_cnt, 0);
      chk("rst_lfsr", dut.lfsr_w, 16'hACE1);
      rst = 1'b0;

      // 1: idle PLAY with head away from the apple
      repeat (100) tick();
      chk("t1_apple_x", apple_x, 24);
      chk("t1_apple_y", apple_y, 10);
      chk("t1_add_cube", add_cube, 0);
      chk("t1_cnt", apple_cnt, 0);
      chk("t1_state", 32'(dut.state_q), 32'(ST_ACTIVE));
      chk("t1_lfsr", dut.lfsr_w, lfsr_m);

      // 6: pixel window of cell (24,10)
      set_pix(384, 160); chk("pix_384_160", apple, 1);
      set_pix(399, 175); chk("pix_399_175", apple, 1);
      set_pix(391, 167); chk("pix_mid", apple, 1);
      set_pix(383, 160); chk("pix_383", apple, 0);
      set_pix(400, 175); chk("pix_400", apple, 0);
      set_pix(390, 159); chk("pix_y159", apple, 0);
      set_pix(390, 176); chk("pix_y176", apple, 0);
      set_pix(384, 160);

      // 2: head steps onto the apple
      head_x = 6'd24; head_y = 6'd10;
      tick();
      chk("t2_add_first", add_cube, 1);
      chk("t2_cnt", apple_cnt, 1);
      chk("t2_pix_eat", apple, 0);
      highs = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (add_cube) highs++;
      end
      chk("t2_pulse_len", highs, 4);
      wait_active("t2_place_timeout");
      chk("t2_x_lo", apple_x >= 1, 1);
      chk("t2_x_hi", apple_x <= 34, 1);
      chk("t2_y_lo", apple_y >= 1, 1);
      chk("t2_y_hi", apple_y <= 24, 1);
      chk("t2_not_head", {apple_x, apple_y} != {6'd24, 6'd10}, 1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (add_cube) seen++;
      end
      chk("t2_no_second", seen, 0);

      // 3: every draw rejected -> fallback cell after 32 PLACE cycles
      head_x = apple_x; head_y = apple_y;
      tick();
      chk("t3_add", add_cube, 1);
      force dut.lfsr_w = 16'h0000;
      head_x = 6'd24; head_y = 6'd10;
      while (dut.state_q == ST_EAT) tick();
      place_cycles = 0;
      set_pix(17 * 16, 12 * 16);
      for (int i = 0; i < 60 && dut.state_q == ST_PLACE; i++) begin
         if (apple) chk("t3_pix_place", apple, 0);
         place_cycles++;
         tick();
      end
      release dut.lfsr_w;
      #1;
      chk("t3_place_len", place_cycles, 32);
      chk("t3_fall_x", apple_x, 17);
      chk("t3_fall_y", apple_y, 12);
      chk("t3_valid", dut.apple_valid_q, 1);
      chk("t3_pix_fall", apple, 1);
      chk("t3_cnt", apple_cnt, 2);
      chk("t3_lfsr", dut.lfsr_w, lfsr_m);

      // 4: RESTART at the 2nd cycle of add_cube
      head_x = 6'd17; head_y = 6'd12;
      tick();
      chk("t4_add1", add_cube, 1);
      chk("t4_cnt3", apple_cnt, 3);
      tick();
      chk("t4_add2", add_cube, 1);
      game_status = GS_RESTART;
      tick();
      chk("t4_add_cut", add_cube, 0);
      chk("t4_x", apple_x, 24);
      chk("t4_y", apple_y, 10);
      chk("t4_cnt", apple_cnt, 0);
      chk("t4_state", 32'(dut.state_q), 32'(ST_ACTIVE));
      chk("t4_lfsr_run", dut.lfsr_w, lfsr_m);
      chk("t4_lfsr_noseed", dut.lfsr_w != 16'hACE1, 1);
      game_status = GS_PLAY;

      // 5: saturate apple_cnt at 255
      for (int k = 0; k < 255; k++) begin
         head_x = apple_x; head_y = apple_y;
         tick();
         wait_active("t5_place_timeout");
      end
      chk("t5_cnt255", apple_cnt, 255);
      head_x = apple_x; head_y = apple_y;
      tick();
      highs = add_cube ? 1 : 0;
      chk("t5_cnt_sat", apple_cnt, 255);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (add_cube) highs++;
      end
      chk("t5_pulse_len", highs, 4);
      wait_active("t5_final_timeout");
      chk("t5_cnt_hold", apple_cnt, 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
